// File: rtl/cam_pkg.sv
// Shared types, payload layout and colour expansion for the DVP capture block.
package cam_pkg;

    typedef enum logic [1:0] {
        ST_WAIT_VS,
        ST_SKIP,
        ST_WAIT_SOF,
        ST_ACTIVE
    } cam_state_e;

    localparam int TDATA_W       = 32;
    localparam int TDATA_B_LSB   = 0;
    localparam int TDATA_G_LSB   = 8;
    localparam int TDATA_R_LSB   = 16;

    // FIFO payload: {tdata, tuser, tlast}
    localparam int PAYLOAD_W     = TDATA_W + 2;
    localparam int PAY_TLAST     = 0;
    localparam int PAY_TUSER     = 1;
    localparam int PAY_TDATA_LSB = 2;

    function automatic logic [TDATA_W-1:0] rgb565_to_888(input logic [7:0] hi,
                                                          input logic [7:0] lo);
        logic [4:0]         r5;
        logic [5:0]         g6;
        logic [4:0]         b5;
        logic [TDATA_W-1:0] px;
        r5 = hi[7:3];
        g6 = {hi[2:0], lo[7:5]};
        b5 = lo[4:0];
        px = '0;
        px[TDATA_R_LSB +: 8] = {r5, r5[4:2]};
        px[TDATA_G_LSB +: 8] = {g6, g6[5:4]};
        px[TDATA_B_LSB +: 8] = {b5, b5[4:2]};
        return px;
    endfunction

endpackage

// File: rtl/cam_pix_fifo.sv
// Pixel FIFO with wrap-around pointers; a push into a full FIFO is dropped
// unless a pop frees the slot in the same cycle.
module cam_pix_fifo
    import cam_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = PAYLOAD_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             empty_o,
    output logic             drop_o
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full || do_pop);
    assign drop_o  = push_i && !do_push;
    assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

    // NOTE: storage has no reset; the read mux forces zero while empty, so stale entries never leak.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
        end
    end

endmodule

// File: rtl/cam_dvp_capture.sv
// DVP RGB565 camera capture to AXI4-Stream RGB888 with settling-frame skip.
// Define CAM_DVP_STATS_EN to build the frame counter and line-format checks.
module cam_dvp_capture
    import cam_pkg::*;
#(
    parameter int FRAME_SKIP = 10,
    parameter int H_ACTIVE   = 1280,
    parameter int FIFO_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cam_vsync,
    input  logic               cam_href,
    input  logic [7:0]         cam_data,
    output logic [TDATA_W-1:0] m_axis_video_tdata,
    output logic               m_axis_video_tvalid,
    input  logic               m_axis_video_tready,
    output logic               m_axis_video_tuser,
    output logic               m_axis_video_tlast,
    output logic               ovf,
    output logic [15:0]        frame_cnt,
    output logic               line_err
);

    logic vs_q, vs_prev_q, href_q, href_prev_q;
    logic [7:0] data_q;
    logic vs_rise, vs_fall, href_fall;

    // NOTE: sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vs_q        <= 1'b0;
            vs_prev_q   <= 1'b0;
            href_q      <= 1'b0;
            href_prev_q <= 1'b0;
            data_q      <= '0;
        end else begin
            vs_q        <= cam_vsync;
            vs_prev_q   <= vs_q;
            href_q      <= cam_href;
            href_prev_q <= href_q;
            data_q      <= cam_data;
        end
    end

    assign vs_rise   = vs_q && !vs_prev_q;
    assign vs_fall   = !vs_q && vs_prev_q;
    assign href_fall = !href_q && href_prev_q;

    cam_state_e  state_q, state_d;
    logic [15:0] skip_cnt_q;
    logic        active, frame_start;

    // NOTE: state_d gets its default before the case so no path infers a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_WAIT_VS:  if (vs_q) state_d = (FRAME_SKIP == 0) ? ST_WAIT_SOF : ST_SKIP;
            ST_SKIP:     if (vs_fall && (skip_cnt_q + 16'd1 >= 16'(FRAME_SKIP))) state_d = ST_WAIT_SOF;
            ST_WAIT_SOF: if (vs_fall) state_d = ST_ACTIVE;
            default:     state_d = state_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_WAIT_VS;
            skip_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q != ST_SKIP) skip_cnt_q <= '0;
            else if (vs_fall)       skip_cnt_q <= skip_cnt_q + 16'd1;
        end
    end

    // The falling edge that enters ACTIVE opens the first forwarded frame.
    assign active      = (state_q == ST_ACTIVE);
    assign frame_start = vs_fall && (state_q == ST_WAIT_SOF || active);

    logic               phase_q, pend_valid_q, arm_q, ovf_q;
    logic [7:0]         hi_q;
    logic [TDATA_W-1:0] pend_px_q;
    logic               pix_done, push, push_last, fifo_drop, fifo_empty;
    logic [PAYLOAD_W-1:0] push_payload, fifo_rdata;

    assign pix_done  = active && href_q && phase_q;
    assign push_last = href_fall || vs_rise;
    assign push      = pend_valid_q && (pix_done || push_last);

    always_comb begin
        push_payload = '0;
        push_payload[PAY_TDATA_LSB +: TDATA_W] = pend_px_q;
        push_payload[PAY_TUSER]                = arm_q;
        push_payload[PAY_TLAST]                = push_last;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q      <= 1'b0;
            hi_q         <= '0;
            pend_px_q    <= '0;
            pend_valid_q <= 1'b0;
            arm_q        <= 1'b0;
            ovf_q        <= 1'b0;
        end else begin
            if (!href_q) begin
                phase_q <= 1'b0;
            end else begin
                phase_q <= !phase_q;
                if (!phase_q) hi_q <= data_q;
            end
            if (pix_done) begin
                pend_px_q    <= rgb565_to_888(hi_q, data_q);
                pend_valid_q <= 1'b1;
            end else if (push) begin
                pend_valid_q <= 1'b0;
            end
            if (frame_start) arm_q <= 1'b1;
            else if (push)   arm_q <= 1'b0;
            if (fifo_drop) ovf_q <= 1'b1;
        end
    end

    cam_pix_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(PAYLOAD_W)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .wdata_i (push_payload),
        .pop_i   (m_axis_video_tready),
        .rdata_o (fifo_rdata),
        .empty_o (fifo_empty),
        .drop_o  (fifo_drop)
    );

    assign m_axis_video_tdata  = fifo_rdata[PAY_TDATA_LSB +: TDATA_W];
    assign m_axis_video_tuser  = fifo_rdata[PAY_TUSER];
    assign m_axis_video_tlast  = fifo_rdata[PAY_TLAST];
    assign m_axis_video_tvalid = !fifo_empty;
    assign ovf                 = ovf_q;

`ifdef CAM_DVP_STATS_EN
    logic [15:0] frame_cnt_q, line_px_q;
    logic        line_err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_cnt_q <= '0;
            line_px_q   <= '0;
            line_err_q  <= 1'b0;
        end else begin
            if (frame_start) frame_cnt_q <= frame_cnt_q + 16'd1;
            if (active && href_fall) begin
                if (phase_q || line_px_q != 16'(H_ACTIVE)) line_err_q <= 1'b1;
                line_px_q <= '0;
            end else if (pix_done && line_px_q != 16'hFFFF) begin
                line_px_q <= line_px_q + 16'd1;
            end
        end
    end

    assign frame_cnt = frame_cnt_q;
    assign line_err  = line_err_q;
`else
    assign frame_cnt = '0;
    assign line_err  = 1'b0;
`endif

endmodule

// File: tb/tb_cam_dvp_capture.sv
// Directed bench for cam_dvp_capture: frame skip, colour expansion, stall/overflow,
// odd-byte lines, frame counting and mid-line reset.
module tb_cam_dvp_capture;
    import cam_pkg::*;

`ifdef CAM_DVP_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        cam_vsync, cam_href;
    logic [7:0]  cam_data;
    logic [31:0] tdata;
    logic        tvalid, tready, tuser, tlast, ovf, line_err;
    logic [15:0] frame_cnt;

    cam_dvp_capture #(.FRAME_SKIP(2), .H_ACTIVE(4), .FIFO_DEPTH(4)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .cam_vsync           (cam_vsync),
        .cam_href            (cam_href),
        .cam_data            (cam_data),
        .m_axis_video_tdata  (tdata),
        .m_axis_video_tvalid (tvalid),
        .m_axis_video_tready (tready),
        .m_axis_video_tuser  (tuser),
        .m_axis_video_tlast  (tlast),
        .ovf                 (ovf),
        .frame_cnt           (frame_cnt),
        .line_err            (line_err)
    );

    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;

    typedef struct packed {
        logic [31:0] d;
        logic        u;
        logic        l;
    } xfer_t;

    xfer_t xq[$];
    int    valid_cycles = 0;

    // Transfers are recorded half a cycle before the edge that completes them.
    always @(negedge clk) begin
        if (tvalid) valid_cycles++;
        if (tvalid && tready) xq.push_back('{d: tdata, u: tuser, l: tlast});
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference expansion: replicate the top bits of each channel into its low bits.
    function automatic logic [31:0] expand(input logic [15:0] p);
        int r, g, b;
        logic [31:0] v;
        r = int'(p[15:11]);
        g = int'(p[10:5]);
        b = int'(p[4:0]);
        r = (r << 3) | (r >> 2);
        g = (g << 2) | (g >> 4);
        b = (b << 3) | (b >> 2);
        v = (r << 16) | (g << 8) | b;
        return v;
    endfunction

    function automatic logic [15:0] stall_px(input int k);
        return 16'(32'hA000 + k * 32'h0123);
    endfunction

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        cam_href = 1'b1;
        cam_data = b;
        step();
    endtask

    task automatic send_px(input logic [15:0] p);
        send_byte(p[15:8]);
        send_byte(p[7:0]);
    endtask

    task automatic end_line();
        cam_href = 1'b0;
        cam_data = 8'h00;
        step(4);
    endtask

    task automatic vsync_pulse();
        cam_vsync = 1'b1;
        step(4);
        cam_vsync = 1'b0;
        step(4);
    endtask

    task automatic wait_xfers(input int target, input string tag);
        int budget = 200;
        while (xq.size() < target && budget > 0) begin
            step();
            budget--;
        end
        step(8);
        check(tag, 64'(xq.size()), 64'(target));
    endtask

    logic [15:0] f3 [8];
    int          base, vbase;
    logic [31:0] held;

    initial begin
        f3 = '{16'hF800, 16'h07E0, 16'h001F, 16'h1234,
               16'hABCD, 16'hFFFF, 16'h0000, 16'h8410};
        rst = 1'b1; cam_vsync = 1'b0; cam_href = 1'b0; cam_data = 8'h00; tready = 1'b1;
        step(3);
        check("rst_tvalid", 64'(tvalid), 64'd0);
        check("rst_tdata", 64'(tdata), 64'd0);
        check("rst_tuser", 64'(tuser), 64'd0);
        check("rst_tlast", 64'(tlast), 64'd0);
        check("rst_ovf", 64'(ovf), 64'd0);
        check("rst_line_err", 64'(line_err), 64'd0);
        check("rst_frame_cnt", 64'(frame_cnt), 64'd0);
        rst = 1'b0;
        step(3);

        // Frames 1-2 are settling frames and must produce nothing.
        vbase = valid_cycles;
        for (int f = 0; f < 2; f++) begin
            vsync_pulse();
            for (int ln = 0; ln < 2; ln++) begin
                for (int i = 0; i < 4; i++) send_px(16'h5A5A);
                end_line();
            end
        end
        check("skip_no_tvalid", 64'(valid_cycles - vbase), 64'd0);

        // Frame 3: first forwarded frame, 2 lines x 4 pixels.
        base = xq.size();
        vsync_pulse();
        for (int ln = 0; ln < 2; ln++) begin
            for (int i = 0; i < 4; i++) send_px(f3[ln*4 + i]);
            end_line();
        end
        wait_xfers(base + 8, "f3_count");
        if (xq.size() >= base + 8) begin
            check("rgb_red", 64'(xq[base+0].d), 64'h00FF0000);
            check("rgb_green", 64'(xq[base+1].d), 64'h0000FF00);
            check("rgb_blue", 64'(xq[base+2].d), 64'h000000FF);
            check("rgb_1234", 64'(xq[base+3].d), 64'h001045A5);
            for (int i = 0; i < 8; i++) begin
                check($sformatf("f3_data%0d", i), 64'(xq[base+i].d), 64'(expand(f3[i])));
                check($sformatf("f3_tuser%0d", i), 64'(xq[base+i].u), 64'(i == 0));
                check($sformatf("f3_tlast%0d", i), 64'(xq[base+i].l), 64'(i == 3 || i == 7));
            end
        end
        check("f3_line_err", 64'(line_err), 64'd0);
        check("f3_frame_cnt", 64'(frame_cnt), STATS ? 64'd1 : 64'd0);
        check("f3_ovf", 64'(ovf), 64'd0);

        // Frame 4: one line of 7 bytes; the trailing high byte is discarded.
        base = xq.size();
        vsync_pulse();
        send_px(16'h1111); send_px(16'h2222); send_px(16'h3333); send_byte(8'h44);
        end_line();
        wait_xfers(base + 3, "odd_count");
        if (xq.size() >= base + 3) begin
            check("odd_tuser0", 64'(xq[base+0].u), 64'd1);
            check("odd_tlast1", 64'(xq[base+1].l), 64'd0);
            check("odd_data2", 64'(xq[base+2].d), 64'(expand(16'h3333)));
            check("odd_tlast2", 64'(xq[base+2].l), 64'd1);
        end
        check("odd_line_err", 64'(line_err), STATS ? 64'd1 : 64'd0);

        // Frame 5: 10-pixel line into a stalled 4-deep FIFO.
        tready = 1'b0;
        base = xq.size();
        vsync_pulse();
        for (int i = 0; i < 10; i++) send_px(stall_px(i));
        end_line();
        check("stall_tvalid", 64'(tvalid), 64'd1);
        check("stall_ovf", 64'(ovf), 64'd1);
        check("stall_head", 64'(tdata), 64'(expand(stall_px(0))));
        held = tdata;
        step(6);
        check("stall_hold_data", 64'(tdata), 64'(held));
        check("stall_hold_tuser", 64'(tuser), 64'd1);
        check("stall_no_xfer", 64'(xq.size() - base), 64'd0);
        tready = 1'b1;
        wait_xfers(base + 4, "stall_count");
        check("stall_drained", 64'(tvalid), 64'd0);
        if (xq.size() >= base + 4) begin
            for (int i = 0; i < 4; i++)
                check($sformatf("stall_data%0d", i), 64'(xq[base+i].d), 64'(expand(stall_px(i))));
        end

        // Frames 6-7: short frames to bring the forwarded count to 5.
        for (int f = 0; f < 2; f++) begin
            base = xq.size();
            vsync_pulse();
            send_px(16'hC0DE); send_px(16'h0F0F);
            end_line();
            wait_xfers(base + 2, $sformatf("short%0d_count", f));
            if (xq.size() >= base + 2) begin
                check($sformatf("short%0d_tuser", f), 64'(xq[base].u), 64'd1);
                check($sformatf("short%0d_tlast", f), 64'(xq[base+1].l), 64'd1);
            end
        end
        check("frame_cnt5", 64'(frame_cnt), STATS ? 64'd5 : 64'd0);

        // Frame 8: reset mid-line with two pixels queued.
        tready = 1'b0;
        vsync_pulse();
        send_px(16'h1357); send_px(16'h2468); send_px(16'h369C); send_byte(8'h77);
        check("pre_rst_tvalid", 64'(tvalid), 64'd1);
        rst = 1'b1;
        #1;
        check("rst_async_tvalid", 64'(tvalid), 64'd0);
        @(negedge clk);
        check("rst_fsm", 64'(dut.state_q), 64'(ST_WAIT_VS));
        check("rst_mid_frame_cnt", 64'(frame_cnt), 64'd0);
        check("rst_mid_ovf", 64'(ovf), 64'd0);
        cam_href = 1'b0;
        cam_data = 8'h00;
        step(2);
        rst = 1'b0;
        tready = 1'b1;
        step(2);

        // Skipping restarts: the first frame after reset is discarded.
        vbase = valid_cycles;
        vsync_pulse();
        for (int i = 0; i < 4; i++) send_px(16'h7E7E);
        end_line();
        step(4);
        check("reskip_no_tvalid", 64'(valid_cycles - vbase), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, tests_failed=%0d", tests_failed);
        $fatal(1, "watchdog expired");
    end

endmodule
